shl_iter: RTL
=============

# shl_iter

Sequential logical left shifter, the left-direction counterpart to the team's combinational right-shift datapath component. It shifts a captured operand left by one bit per clock until `sh_amt` positions are done, filling with zeros, then reports completion with a `done` pulse. It is used where a full barrel shifter costs too much area, and it trades latency for area in the scheduled datapath.

## Interface
- `DATAWIDTH`, default 2: operand and result width in bits, ≥ 2.
- `Clk` in, 1: clock; every register updates on the rising edge.
- `Rst` in, 1: asynchronous, active-low reset.
- `start` in, 1: request a new shift; sampled only in IDLE.
- `a` in, `DATAWIDTH`: operand; captured on the accepting edge only.
- `sh_amt` in, `$clog2(DATAWIDTH)`: shift distance, 0 to 2^w−1; captured on the accepting edge only.
- `d` out, `DATAWIDTH`: result register; holds the last result until the next accepted start.
- `busy` out, 1: high in SHIFT and DONE.
- `done` out, 1: high only in DONE, a single-cycle pulse per operation.

## Operation
- States: IDLE, SHIFT, DONE.
  - Encoding is free.
  - `busy` and `done` decode from state only, with no combinational path from inputs.
- IDLE with `start`=1 at an edge:
  - `d` ← `a`, `cnt` ← `sh_amt`.
  - Next state is DONE if `sh_amt`==0, else SHIFT.
- IDLE with `start`=0: all registers hold.
- SHIFT, each edge:
  - `d` ← {`d`[DATAWIDTH−2:0], 1'b0}; `cnt` ← `cnt`−1.
  - If `cnt`==1 before the edge, next state is DONE.
- DONE: one cycle, then IDLE unconditionally. `d` holds.
- `start` in SHIFT or DONE is ignored, not queued. `a`/`sh_amt` changes after capture have no effect.
- Arithmetic:
  - Bits shifted out of the MSB are discarded; LSBs fill with 0.
  - The result equals `a << sh_amt` truncated to `DATAWIDTH`.
- `sh_amt` can reach 2^w−1 when `DATAWIDTH` is not a power of 2. Shifts ≥ `DATAWIDTH` give `d`=0; still take `sh_amt` SHIFT cycles.
- `cnt` is `$clog2(DATAWIDTH)` bits wide. It never wraps, because SHIFT exits at `cnt`==1.

## Timing
- Reset (`Rst`=0, any time, asynchronous):
  - State goes to IDLE; `d`=0, `cnt`=0, `busy`=0, `done`=0 immediately.
  - An operation in progress is abandoned with no `done` pulse.
- Reset release: the first edge with `Rst`=1 may accept `start`.
- Latency: with `start` accepted at edge E0, `done` is high from edge E0+`sh_amt` to edge E0+`sh_amt`+1.
  - `sh_amt`=0 gives `done` in the cycle immediately after E0.
- `d` is valid (final) whenever `done`=1 and stays valid through IDLE.
- Intermediate `d` values during SHIFT are visible and are partial shifts; consumers must wait for `done`.
- Back-to-back: the earliest next acceptance is edge E0+`sh_amt`+2, the first IDLE edge. Throughput is one op per `sh_amt`+2 cycles.

## Test plan
- Reset mid-operation: `DATAWIDTH`=8.
  - Accept `a`=8'hFF, `sh_amt`=5, then assert `Rst` low after 2 SHIFT edges.
  - Required: `d`=0, `busy`=0, `done`=0 at once, and no `done` pulse ever.
  - After release, `a`=8'h01, `sh_amt`=1 → `d`=8'h02.
- Basic shift: `DATAWIDTH`=8, `a`=8'h81, `sh_amt`=3, `start` for 1 cycle.
  - `busy` is high 4 cycles; `done` is high exactly 1 cycle, 3 edges after acceptance.
  - `d`=8'h08 at `done` and held afterwards.
- Zero shift: `a`=8'hA5, `sh_amt`=0.
  - `done` is high the cycle after acceptance; `d`=8'hA5; `busy` is high 1 cycle.
- Max shift and ignored start: `a`=8'hFF, `sh_amt`=7.
  - Pulse `start` with `a`=8'h00 during SHIFT.
  - Required: `d`=8'h80 at `done`; the second start is ignored.
  - `start` held high continuously gives back-to-back ops spaced 9 cycles.
- Non-power-of-2 width: `DATAWIDTH`=5, `a`=5'b10111.
  - `sh_amt`=2 → `d`=5'b11100.
  - `sh_amt`=6 → `d`=0 with `done` 6 edges after acceptance.

Source files
------------

// File: rtl/shl_iter.sv
// Iterative logical left shifter: one bit position per clock.
// Trades latency for area against a full barrel shifter.
module shl_iter #(
  parameter int DATAWIDTH = 2
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic                         start,
  input  logic [DATAWIDTH-1:0]         a,
  input  logic [$clog2(DATAWIDTH)-1:0] sh_amt,
  output logic [DATAWIDTH-1:0]         d,
  output logic                         busy,
  output logic                         done
);

  localparam int AW = $clog2(DATAWIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [DATAWIDTH-1:0]   d_q, d_d;
  logic [AW-1:0]          cnt_q, cnt_d;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
      d_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          d_d     = a;
          cnt_d   = sh_amt;
          state_d = (sh_amt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        d_d   = {d_q[DATAWIDTH-2:0], 1'b0};
        cnt_d = cnt_q - AW'(1);
        // Exit on the last step so cnt never wraps below zero
        if (cnt_q == AW'(1)) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign d    = d_q;
  assign busy = (state_q == SHIFT) || (state_q == DONE);
  assign done = (state_q == DONE);

endmodule
